// File: rtl/reg_checker.sv
// Cycle-accurate checker for a D register: mirrors the expected Q from the
// sampled D/reset taps, compares against the observed Q, and records failures.
module reg_checker #(
  parameter int unsigned WORD    = 32,
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned MAX_ERR = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             dut_rst,
  input  logic [WORD-1:0]  d,
  input  logic [WORD-1:0]  q,
  output logic             mismatch,
  output logic             fail,
  output logic             halted,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] chk_count,
  output logic [WORD-1:0]  first_exp,
  output logic [WORD-1:0]  first_act,
  output logic [CNT_W-1:0] first_idx
);

  typedef enum logic [1:0] {S_IDLE, S_PRIME, S_CHECK, S_HALT} state_e;

  // One extra bit so a MAX_ERR above the counter range can never match.
  localparam logic [CNT_W:0] MAX_ERR_W = (CNT_W+1)'(MAX_ERR);

  state_e           state_q, state_d;
  logic [WORD-1:0]  exp_q, exp_d;
  logic             mismatch_q, mismatch_d;
  logic             fail_q, fail_d;
  logic             halted_q, halted_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic [CNT_W-1:0] chk_q, chk_d;
  logic [WORD-1:0]  first_exp_q, first_exp_d;
  logic [WORD-1:0]  first_act_q, first_act_d;
  logic [CNT_W-1:0] first_idx_q, first_idx_d;
  logic [WORD-1:0]  model_c;

  // Value the register under test captures at this edge.
  assign model_c = dut_rst ? '0 : d;

  always_comb begin
    state_d     = state_q;
    exp_d       = exp_q;
    mismatch_d  = 1'b0;
    fail_d      = fail_q;
    err_d       = err_q;
    chk_d       = chk_q;
    first_exp_d = first_exp_q;
    first_act_d = first_act_q;
    first_idx_d = first_idx_q;

    unique case (state_q)
      S_IDLE: begin
        if (enable) state_d = S_PRIME;
      end
      S_PRIME: begin
        exp_d   = model_c;
        state_d = enable ? S_CHECK : S_IDLE;
      end
      S_CHECK: begin
        if (!enable) begin
          state_d = S_IDLE;
        end else begin
          exp_d = model_c;
          chk_d = (chk_q == '1) ? chk_q : chk_q + CNT_W'(1);
          // Case inequality so X/Z on q is reported as a failure.
          if (q !== exp_q) begin
            mismatch_d = 1'b1;
            err_d      = (err_q == '1) ? err_q : err_q + CNT_W'(1);
            if (!fail_q) begin
              fail_d      = 1'b1;
              first_exp_d = exp_q;
              first_act_d = q;
              first_idx_d = chk_q;
            end
            if ((MAX_ERR != 0) && ({1'b0, err_d} == MAX_ERR_W)) state_d = S_HALT;
          end
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    halted_d = (state_d == S_HALT);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      exp_q       <= '0;
      mismatch_q  <= 1'b0;
      fail_q      <= 1'b0;
      halted_q    <= 1'b0;
      err_q       <= '0;
      chk_q       <= '0;
      first_exp_q <= '0;
      first_act_q <= '0;
      first_idx_q <= '0;
    end else begin
      state_q     <= state_d;
      exp_q       <= exp_d;
      mismatch_q  <= mismatch_d;
      fail_q      <= fail_d;
      halted_q    <= halted_d;
      err_q       <= err_d;
      chk_q       <= chk_d;
      first_exp_q <= first_exp_d;
      first_act_q <= first_act_d;
      first_idx_q <= first_idx_d;
    end
  end

  assign mismatch  = mismatch_q;
  assign fail      = fail_q;
  assign halted    = halted_q;
  assign err_count = err_q;
  assign chk_count = chk_q;
  assign first_exp = first_exp_q;
  assign first_act = first_act_q;
  assign first_idx = first_idx_q;

endmodule

// File: tb/tb_reg_checker.sv
// Scoreboard bench for reg_checker: a behavioural register drives q, directed
// stimulus queues hand-computed expected outputs, a monitor compares them.
module tb_reg_checker;

  logic        clk;
  logic        reset;
  logic        enable;
  logic        dut_rst;
  logic [31:0] d;
  logic [31:0] q;
  logic        mismatch;
  logic        fail;
  logic        halted;
  logic [15:0] err_count;
  logic [15:0] chk_count;
  logic [31:0] first_exp;
  logic [31:0] first_act;
  logic [15:0] first_idx;

  logic        force_en;
  logic [31:0] force_val;
  logic [31:0] q_rut = '0;

  typedef struct packed {
    logic        mism;
    logic        fail;
    logic        halted;
    logic [15:0] err;
    logic [15:0] chk;
    logic [31:0] fexp;
    logic [31:0] fact;
    logic [15:0] fidx;
  } obs_t;

  obs_t  sb_q[$];
  string sb_name[$];
  int    checks   = 0;
  int    failures = 0;

  reg_checker #(.WORD(32), .CNT_W(16), .MAX_ERR(3)) dut (
    .clk(clk), .reset(reset), .enable(enable), .dut_rst(dut_rst),
    .d(d), .q(q), .mismatch(mismatch), .fail(fail), .halted(halted),
    .err_count(err_count), .chk_count(chk_count),
    .first_exp(first_exp), .first_act(first_act), .first_idx(first_idx)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Correct register under test, with a fault-injection override on q.
  always_ff @(posedge clk) q_rut <= dut_rst ? 32'd0 : d;
  assign q = force_en ? force_val : q_rut;

  // Monitor: compares each queued expectation at the falling edge.
  always @(negedge clk) begin
    if (sb_q.size() != 0) begin
      obs_t  e;
      obs_t  a;
      string n;
      e = sb_q.pop_front();
      n = sb_name.pop_front();
      a = '{mism: mismatch, fail: fail, halted: halted, err: err_count,
            chk: chk_count, fexp: first_exp, fact: first_act, fidx: first_idx};
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL %s: got mism=%b fail=%b halt=%b err=%0d chk=%0d fexp=%h fact=%h fidx=%0d; want mism=%b fail=%b halt=%b err=%0d chk=%0d fexp=%h fact=%h fidx=%0d",
                 n, a.mism, a.fail, a.halted, a.err, a.chk, a.fexp, a.fact, a.fidx,
                 e.mism, e.fail, e.halted, e.err, e.chk, e.fexp, e.fact, e.fidx);
      end
    end
  end

  // Advance one edge and queue the outputs expected right after it.
  task automatic tick(input string name, input logic mi, input logic fa, input logic ha,
                      input int er, input int ch, input logic [31:0] fe,
                      input logic [31:0] fc, input int fi);
    obs_t e;
    @(posedge clk);
    #1;
    e = '{mism: mi, fail: fa, halted: ha, err: 16'(er), chk: 16'(ch),
          fexp: fe, fact: fc, fidx: 16'(fi)};
    sb_q.push_back(e);
    sb_name.push_back(name);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; enable = 1'b0; dut_rst = 1'b0; d = '0;
    force_en = 1'b0; force_val = '0;
    tick("reset0", 0, 0, 0, 0, 0, 0, 0, 0);
    tick("reset1", 0, 0, 0, 0, 0, 0, 0, 0);

    // Clean run: IDLE->PRIME, PRIME (no compare), then d = 0,1,2.
    reset = 1'b1; enable = 1'b1; d = 32'd0;
    tick("idle_to_prime", 0, 0, 0, 0, 0, 0, 0, 0);
    d = 32'd0;
    tick("prime_no_cmp", 0, 0, 0, 0, 0, 0, 0, 0);
    d = 32'd1;
    tick("clean_d1", 0, 0, 0, 0, 1, 0, 0, 0);
    d = 32'd2;
    tick("clean_d2", 0, 0, 0, 0, 2, 0, 0, 0);
    // Mid-cycle 2->3: only the edge value counts.
    d = 32'd2; #1 d = 32'd3;
    tick("mid_change", 0, 0, 0, 0, 3, 0, 0, 0);
    dut_rst = 1'b1;
    tick("dut_rst1", 0, 0, 0, 0, 4, 0, 0, 0);
    d = 32'hFFFF_FFFF;
    tick("dut_rst_wins", 0, 0, 0, 0, 5, 0, 0, 0);
    dut_rst = 1'b0; d = 32'd1;
    tick("rst_release", 0, 0, 0, 0, 6, 0, 0, 0);

    // Fault injection: q forced to 5 while the model expects 1.
    force_en = 1'b1; force_val = 32'd5;
    tick("fault_pulse", 1, 1, 0, 1, 7, 32'd1, 32'd5, 6);
    force_en = 1'b0;
    tick("fault_single", 0, 1, 0, 1, 8, 32'd1, 32'd5, 6);

    // Enable low for three edges, then PRIME, then clean resume.
    enable = 1'b0; d = 32'd7;
    tick("en_low1", 0, 1, 0, 1, 8, 32'd1, 32'd5, 6);
    tick("en_low2", 0, 1, 0, 1, 8, 32'd1, 32'd5, 6);
    tick("en_low3", 0, 1, 0, 1, 8, 32'd1, 32'd5, 6);
    enable = 1'b1; d = 32'd8;
    tick("reenable_idle", 0, 1, 0, 1, 8, 32'd1, 32'd5, 6);
    d = 32'd9;
    tick("reenable_prime", 0, 1, 0, 1, 8, 32'd1, 32'd5, 6);
    d = 32'd10;
    tick("resume_clean", 0, 1, 0, 1, 9, 32'd1, 32'd5, 6);

    // Second error keeps first captures; then reset mid-CHECK clears all.
    force_en = 1'b1; force_val = 32'hAB;
    tick("second_err", 1, 1, 0, 2, 10, 32'd1, 32'd5, 6);
    force_en = 1'b0; reset = 1'b0;
    tick("reset_mid_check", 0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1; d = 32'h11;
    tick("post_rst_idle", 0, 0, 0, 0, 0, 0, 0, 0);
    d = 32'h22;
    tick("post_rst_prime", 0, 0, 0, 0, 0, 0, 0, 0);
    d = 32'h33;
    tick("post_rst_check", 0, 0, 0, 0, 1, 0, 0, 0);

    // q stuck at 0 while d counts: halts on the third error.
    force_en = 1'b1; force_val = 32'd0; d = 32'd1;
    tick("stuck_err1", 1, 1, 0, 1, 2, 32'h33, 32'd0, 1);
    d = 32'd2;
    tick("stuck_err2", 1, 1, 0, 2, 3, 32'h33, 32'd0, 1);
    d = 32'd3;
    tick("halt_entry", 1, 1, 1, 3, 4, 32'h33, 32'd0, 1);
    d = 32'd4;
    tick("halt_frozen1", 0, 1, 1, 3, 4, 32'h33, 32'd0, 1);
    d = 32'd5; enable = 1'b0;
    tick("halt_frozen2", 0, 1, 1, 3, 4, 32'h33, 32'd0, 1);
    reset = 1'b0;
    tick("halt_reset", 0, 0, 0, 0, 0, 0, 0, 0);

    repeat (3) @(negedge clk);
    #1;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending, want 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
